// File: rtl/cpu_oam_dma_pkg.sv
// Shared types and constants for the sprite DMA engine.
// State encoding is 3 bits so ALIGN fits when OAM_DMA_ODD_ALIGN_EN is set.
package cpu_dma_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DUMMY = 3'd1,
    S_ALIGN = 3'd2,
    S_READ  = 3'd3,
    S_WRITE = 3'd4
  } dma_state_t;

  localparam logic [15:0] DMA_TRIGGER_ADDR = 16'h4014;
  localparam logic [15:0] OAMDATA_ADDR     = 16'h2004;
  localparam int          DMA_BYTES        = 256;

endpackage

// File: rtl/cpu_oam_dma_if.sv
// CPU snoop inputs and DMA bus outputs of the sprite DMA engine.
// master = console/bench side, slave = the DMA engine.
interface cpu_oam_dma_if;

  logic [15:0] i_CPU_ADDR;
  logic [7:0]  i_CPU_DATA;
  logic        i_CPU_R_WN;
  logic [7:0]  i_BUS_DATA;

  logic        o_PAUSE;
  logic        o_DMA_ACTIVE;
  logic [15:0] o_DMA_ADDR;
  logic [7:0]  o_DMA_DATA;
  logic        o_DMA_R_WN;
  logic        o_BUSY;

  modport master (
    output i_CPU_ADDR,
    output i_CPU_DATA,
    output i_CPU_R_WN,
    output i_BUS_DATA,
    input  o_PAUSE,
    input  o_DMA_ACTIVE,
    input  o_DMA_ADDR,
    input  o_DMA_DATA,
    input  o_DMA_R_WN,
    input  o_BUSY
  );

  modport slave (
    input  i_CPU_ADDR,
    input  i_CPU_DATA,
    input  i_CPU_R_WN,
    input  i_BUS_DATA,
    output o_PAUSE,
    output o_DMA_ACTIVE,
    output o_DMA_ADDR,
    output o_DMA_DATA,
    output o_DMA_R_WN,
    output o_BUSY
  );

endinterface

// File: rtl/cpu_oam_dma.sv
// Sprite DMA: a $4014 write copies page $XX00-$XXFF into OAMDATA.
// Define OAM_DMA_ODD_ALIGN_EN to add the odd-cycle ALIGN stall.
module cpu_oam_dma
  import cpu_dma_pkg::*;
#(
  parameter logic [15:0] TRIGGER_ADDR = DMA_TRIGGER_ADDR,
  parameter logic [15:0] OAMDATA_ADDR = cpu_dma_pkg::OAMDATA_ADDR
) (
  input  logic          i_CLK,
  input  logic          i_RST_N,
  cpu_oam_dma_if.slave  bus
);

  dma_state_t  state;
  logic [7:0]  page;
  logic [7:0]  cnt;
  logic [7:0]  latch;
  logic        trig;
  logic        last;

`ifdef OAM_DMA_ODD_ALIGN_EN
  logic        r_odd;

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) r_odd <= 1'b0;
    else          r_odd <= ~r_odd;
  end
`endif

  assign trig = !bus.i_CPU_R_WN &&
                (bus.i_CPU_ADDR == TRIGGER_ADDR);
  assign last = (cnt == 8'(DMA_BYTES - 1));

  always_ff @(posedge i_CLK or negedge i_RST_N) begin
    if (!i_RST_N) begin
      state <= S_IDLE;
      page  <= 8'h00;
      cnt   <= 8'h00;
      latch <= 8'h00;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (trig) begin
            page  <= bus.i_CPU_DATA;
            state <= S_DUMMY;
          end
        end
        S_DUMMY: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
          state <= r_odd ? S_ALIGN : S_READ;
`else
          state <= S_READ;
`endif
        end
`ifdef OAM_DMA_ODD_ALIGN_EN
        S_ALIGN: state <= S_READ;
`endif
        S_READ: begin
          latch <= bus.i_BUS_DATA;
          state <= S_WRITE;
        end
        S_WRITE: begin
          // cnt wraps to 0 on the last byte; page never advances
          cnt   <= cnt + 8'd1;
          state <= last ? S_IDLE : S_READ;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Outputs decode only from registered state, page, cnt and latch.
  always_comb begin
    bus.o_DMA_ACTIVE = 1'b0;
    bus.o_DMA_ADDR   = 16'h0000;
    bus.o_DMA_DATA   = 8'h00;
    bus.o_DMA_R_WN   = 1'b1;
    unique case (1'b1)
      (state == S_READ): begin
        bus.o_DMA_ACTIVE = 1'b1;
        bus.o_DMA_ADDR   = {page, cnt};
      end
      (state == S_WRITE): begin
        bus.o_DMA_ACTIVE = 1'b1;
        bus.o_DMA_ADDR   = OAMDATA_ADDR;
        bus.o_DMA_DATA   = latch;
        bus.o_DMA_R_WN   = 1'b0;
      end
      default: ;
    endcase
  end

  assign bus.o_PAUSE = (state != S_IDLE);
  assign bus.o_BUSY  = (state != S_IDLE);

endmodule

// File: tb/tb_cpu_oam_dma.sv
// Scoreboard bench for cpu_oam_dma against a random memory model.
// Expected pause length honours OAM_DMA_ODD_ALIGN_EN when defined.
module tb_cpu_oam_dma;
  import cpu_dma_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_oam_dma_if bus ();

  cpu_oam_dma dut (
    .i_CLK   (clk),
    .i_RST_N (rst_n),
    .bus     (bus)
  );

  typedef struct {
    logic [15:0] addr;
    logic        rwn;
    logic [7:0]  data;
  } acc_t;

  acc_t exp_q[$];
  int   plen_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [7:0] mem [65536];
  assign bus.i_BUS_DATA = mem[bus.o_DMA_ADDR];

`ifdef OAM_DMA_ODD_ALIGN_EN
  int edges;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
`endif

  task automatic check(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every DMA-owned bus cycle and every pause run
  initial begin
    int   run;
    acc_t e;
    run = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        run = 0;
        continue;
      end
      if (bus.o_DMA_ACTIVE) begin
        if (exp_q.size() == 0) begin
          check("unexpected_access", 32'(bus.o_DMA_ADDR), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("dma_addr", 32'(bus.o_DMA_ADDR), 32'(e.addr));
          check("dma_r_wn", 32'(bus.o_DMA_R_WN), 32'(e.rwn));
          check("dma_data", 32'(bus.o_DMA_DATA), 32'(e.data));
        end
      end
      if (bus.o_PAUSE) begin
        run++;
      end else if (run != 0) begin
        if (plen_q.size() == 0)
          check("unexpected_pause", 32'(run), 32'd0);
        else
          check("pause_len", 32'(run), 32'(plen_q.pop_front()));
        run = 0;
      end
    end
  end

  task automatic idle_cpu();
    logic [15:0] a;
    a = 16'($urandom);
    if (a == DMA_TRIGGER_ADDR) a = 16'h0000;
    bus.i_CPU_ADDR = a;
    bus.i_CPU_R_WN = 1'($urandom_range(0, 1));
    bus.i_CPU_DATA = 8'($urandom);
  endtask

  // Call while idle, away from posedge; returns just after trigger edge
  task automatic trigger(input logic [7:0] p);
    int odd;
    logic [15:0] a;
    bus.i_CPU_ADDR = DMA_TRIGGER_ADDR;
    bus.i_CPU_R_WN = 1'b0;
    bus.i_CPU_DATA = p;
    @(posedge clk);
    #1;
    odd = 0;
`ifdef OAM_DMA_ODD_ALIGN_EN
    odd = edges % 2;
`endif
    plen_q.push_back(513 + odd);
    for (int i = 0; i < 256; i++) begin
      a = {p, 8'(i)};
      exp_q.push_back('{addr: a, rwn: 1'b1, data: 8'h00});
      exp_q.push_back('{addr: 16'h2004, rwn: 1'b0, data: mem[a]});
    end
    idle_cpu();
  endtask

  // Full transfer; stray $4014 writes while paused must be ignored
  task automatic run_transfer(input logic [7:0] p);
    int k;
    trigger(p);
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      k++;
      if (!bus.o_PAUSE) break;
      if ($urandom_range(0, 3) == 0) begin
        bus.i_CPU_ADDR = DMA_TRIGGER_ADDR;
        bus.i_CPU_R_WN = 1'b0;
        bus.i_CPU_DATA = 8'($urandom);
      end else begin
        idle_cpu();
      end
    end
    idle_cpu();
    if (k >= 2000) check("pause_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_idle_outputs(input string nm);
    check({nm, "_pause"},  32'(bus.o_PAUSE), 32'd0);
    check({nm, "_active"}, 32'(bus.o_DMA_ACTIVE), 32'd0);
    check({nm, "_busy"},   32'(bus.o_BUSY), 32'd0);
    check({nm, "_addr"},   32'(bus.o_DMA_ADDR), 32'd0);
    check({nm, "_data"},   32'(bus.o_DMA_DATA), 32'd0);
    check({nm, "_r_wn"},   32'(bus.o_DMA_R_WN), 32'd1);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      idle_cpu();
    end
  endtask

  initial begin
    int k;
    logic [7:0] p;
    for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++)
      mem[{8'h02, 8'(i)}] = 8'(i) ^ 8'hA5;
    idle_cpu();
    bus.i_CPU_R_WN = 1'b1;

    #12;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    gap(2);

    // Near-miss accesses must not start a transfer
    bus.i_CPU_ADDR = 16'h4013; bus.i_CPU_R_WN = 1'b0;
    @(negedge clk);
    bus.i_CPU_ADDR = 16'h4015; bus.i_CPU_R_WN = 1'b0;
    @(negedge clk);
    bus.i_CPU_ADDR = 16'h4014; bus.i_CPU_R_WN = 1'b1;
    @(negedge clk);
    idle_cpu();
    @(negedge clk);
    check_idle_outputs("nontrig");

    run_transfer(8'h02);
    gap(3);
    run_transfer(8'hFF);
    run_transfer(8'($urandom));
    run_transfer(8'($urandom));
    for (int t = 0; t < 4; t++) begin
      gap($urandom_range(0, 3));
      run_transfer(8'($urandom));
    end

    // Abort at byte 100
    p = 8'($urandom);
    trigger(p);
    k = 0;
    while (k < 2000) begin
      @(negedge clk);
      k++;
      if (bus.o_DMA_ACTIVE && bus.o_DMA_ADDR == {p, 8'd100}) break;
    end
    if (k >= 2000) check("byte100_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    plen_q.delete();
    #1;
    check_idle_outputs("abort");
    gap(2);
    #2;
    rst_n = 1'b1;
    gap(2);
    run_transfer(8'($urandom));
    gap(2);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("plen_q_drained", 32'(plen_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/cpu_oam_dma.md
Name: cpu_oam_dma

Overview:
- Sprite DMA engine on the CPU bus, driving the CPU's pause input.
- A CPU write to the trigger register ($4014) starts a copy of one 256-byte page, $XX00–$XXFF, into PPU OAMDATA ($2004).
- While the copy runs, the engine pauses the CPU and owns the bus through a top-level address/data mux selected by o_DMA_ACTIVE.

Parameters:
- TRIGGER_ADDR, 16'h4014, CPU write address that starts a DMA.
- OAMDATA_ADDR, 16'h2004, destination address for every DMA write.

Ports:
- i_CLK  in  1  CPU clock (1.79 MHz).
- i_RST_N  in  1  Async active-low reset.
- i_CPU_ADDR  in  16  CPU address bus, snooped.
- i_CPU_DATA  in  8  CPU write data, snooped.
- i_CPU_R_WN  in  1  CPU read/write_n, snooped.
- i_BUS_DATA  in  8  Read data returned from the system bus.
- o_PAUSE  out  1  Stalls the CPU; the CPU releases the bus while this is high.
- o_DMA_ACTIVE  out  1  Bus mux select: DMA owns address, data and R/W.
- o_DMA_ADDR  out  16  DMA bus address.
- o_DMA_DATA  out  8  DMA write data.
- o_DMA_R_WN  out  1  DMA read/write_n; 1 = read.
- o_BUSY  out  1  Debug: state is not IDLE.

Behaviour:
- Reset: i_RST_N is asynchronous, active-low; clock is i_CLK. While in reset, all outputs take these values:
  - o_PAUSE = 0, o_DMA_ACTIVE = 0, o_BUSY = 0.
  - o_DMA_ADDR = 0, o_DMA_DATA = 0, o_DMA_R_WN = 1.
  - State = IDLE, page register = 0, byte counter = 0, data latch = 0.
- Trigger: sampled on a posedge with state == IDLE, i_CPU_R_WN == 0 and i_CPU_ADDR == TRIGGER_ADDR. That edge latches page <= i_CPU_DATA and moves to DUMMY.
- A trigger-address write while not IDLE is ignored; it cannot occur anyway, since the CPU is paused.
- States, registered:
  - IDLE: outputs at reset values.
  - DUMMY: exactly 1 cycle. o_PAUSE = 1, o_DMA_ACTIVE = 0. Next state is READ (or ALIGN, see Optional Feature).
  - READ: o_PAUSE = 1, o_DMA_ACTIVE = 1, o_DMA_ADDR = {page, cnt}, o_DMA_R_WN = 1. On the edge, data latch <= i_BUS_DATA. Next state WRITE.
  - WRITE: o_PAUSE = 1, o_DMA_ACTIVE = 1, o_DMA_ADDR = OAMDATA_ADDR, o_DMA_DATA = latch, o_DMA_R_WN = 0. On the edge, cnt <= cnt + 1 (8-bit). If cnt == 8'hFF, next state IDLE; otherwise READ.
- Output generation: all outputs decode directly from registered state, counter and latch. There are no combinational paths from inputs to outputs.
- Timing, trigger seen at edge T:
  - o_PAUSE is high for cycles T+1 .. T+513 (513 cycles).
  - First read at T+2; last write at T+513.
  - o_PAUSE is low again at T+514.
- Counter width: cnt is 8 bits and wraps to 0 at the end. The page never increments, so page $FF reads $FF00–$FFFF only.
- o_DMA_DATA is 0 outside WRITE. o_DMA_ADDR is 0 in IDLE and DUMMY.
- Reset mid-transfer: the engine aborts immediately to IDLE and o_PAUSE drops asynchronously. A partially written OAM is accepted.
- Parity flop: r_odd toggles every clock from reset (reset value 0). It is used only by the optional feature.

Optional Feature:
- Macro: OAM_DMA_ODD_ALIGN_EN.
- Defined:
  - On leaving DUMMY with r_odd == 1, the engine enters ALIGN for one extra cycle: o_PAUSE = 1, o_DMA_ACTIVE = 0.
  - It then proceeds to READ, so an odd start gives 514 paused cycles.
  - With r_odd == 0, behaviour is identical to the baseline.
- Not defined: the ALIGN state and r_odd are absent, and the transfer is always 513 cycles.

Decomposition:
- Package cpu_dma_pkg holds:
  - the state encoding (IDLE, DUMMY, ALIGN, READ, WRITE, 3 bits);
  - DMA_TRIGGER_ADDR = 16'h4014;
  - OAMDATA_ADDR = 16'h2004;
  - DMA_BYTES = 256.
- Single flat module; no sub-module is warranted. The bus mux lives in the console top level, not in this block.

Test Plan:
- Basic transfer: CPU writes 8'h02 to $4014; bus model returns low address byte XOR 8'hA5 → o_PAUSE high for exactly 513 cycles. 256 reads of $0200..$02FF, each followed by a write to $2004 of the expected byte. o_PAUSE low at T+514.
- Page wrap: trigger with 8'hFF → last read address $FFFF, last write to $2004, then IDLE. No access to $0000.
- Non-trigger writes: CPU writes to $4013, $4015, and a read of $4014 → no state change, o_PAUSE stays 0.
- Reset mid-op: assert i_RST_N low at byte 100 →
  - o_PAUSE and o_DMA_ACTIVE are 0 asynchronously; o_DMA_R_WN is 1.
  - After release, a new trigger runs a full 513-cycle transfer from cnt 0.
- Back-to-back: a second trigger issued 1 cycle after o_PAUSE falls → a second full transfer, pause 513 cycles again.
- With OAM_DMA_ODD_ALIGN_EN defined: trigger on an even and an odd parity cycle → pause lengths 513 and 514 respectively. Data and addresses are identical in both cases.
